// File: rtl/hazard_ctrl.sv
// Hazard and memory-stall controller for the 5-stage MIPS pipeline: operand forwarding,
// load-use/branch interlocks, and a wait-state FSM that locks into an error state on a stuck access.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state, stateNext;
  logic [7:0] WaitCnt, WaitCntNext;
  logic       lwstall, branchstall, MemStall;

  // Execute-stage forwarding: the younger M-stage result wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    if (RsE != 5'd0 && RegWriteM && RsE == WriteRegM)
      ForwardAE = 2'b10;
    else if (RsE != 5'd0 && RegWriteW && RsE == WriteRegW)
      ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RtE != 5'd0 && RegWriteM && RtE == WriteRegM)
      ForwardBE = 2'b10;
    else if (RtE != 5'd0 && RegWriteW && RtE == WriteRegW)
      ForwardBE = 2'b01;
  end

  assign ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
  assign ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);

  assign lwstall = MemtoRegE && ((RsD == RtE) || (RtD == RtE));

  // Branch compare in Decode needs its operands a stage earlier than the ALU does.
  assign branchstall = BranchD &&
                       ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                        (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));

  assign MemStall = (state == ERR) || (MemReqM && !MemReadyM);

  // A held M stage outranks the Decode interlock; the interlock re-evaluates once M releases.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (MemStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (lwstall || branchstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    stateNext   = state;
    WaitCntNext = WaitCnt;
    unique case (state)
      IDLE: begin
        if (MemStall) begin
          stateNext   = WAIT;
          WaitCntNext = 8'd1;
        end else begin
          WaitCntNext = '0;
        end
      end
      WAIT: begin
        if (MemReadyM || !MemReqM) begin
          stateNext   = IDLE;
          WaitCntNext = '0;
        end else if (WaitCnt == TIMEOUT_CNT) begin
          stateNext = ERR;
        end else begin
          WaitCntNext = WaitCnt + 8'd1;
        end
      end
      ERR: begin
        stateNext = ERR;
      end
      default: begin
        stateNext   = IDLE;
        WaitCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      WaitCnt    <= '0;
      MemErr     <= 1'b0;
      StallCount <= '0;
    end else begin
      state   <= stateNext;
      WaitCnt <= WaitCntNext;
      if (stateNext == ERR)
        MemErr <= 1'b1;
      if (StallF && StallCount != '1)
        StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4) with hand-computed expectations.
module tb_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       rst;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic       StallF, StallD, StallE, StallM, FlushE, FlushW, MemErr;
  logic [3:0] StallCount;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .Clk(Clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr), .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bits in order {StallF,StallD,StallE,StallM,FlushE,FlushW}
  task automatic chkCtl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, StallF, StallD, StallE, StallM, FlushE, FlushW}, {26'd0, exp});
  endtask

  task automatic clearIn();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setLwstall();
    MemtoRegE = 1; RtE = 3; RsD = 3;
  endtask

  initial begin
    rst = 1'b1;
    clearIn();
    #1;
    chkCtl("reset_ctl", 6'b000000);
    chk("reset_fwdAE", 32'(ForwardAE), 32'd0);
    chk("reset_fwdD", {30'd0, ForwardAD, ForwardBD}, 32'd0);
    chk("reset_cnt", 32'(StallCount), 32'd0);
    chk("reset_err", 32'(MemErr), 32'd0);
    tick();
    rst = 1'b0;

    // Forwarding
    RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 5;
    #1;
    chk("fwdAE_M_prio", 32'(ForwardAE), 32'h2);
    chk("fwdBE_M_prio", 32'(ForwardBE), 32'h2);
    RegWriteM = 0;
    #1;
    chk("fwdAE_W", 32'(ForwardAE), 32'h1);
    RsE = 0; WriteRegM = 0; RegWriteM = 1; WriteRegW = 0;
    #1;
    chk("fwdAE_r0", 32'(ForwardAE), 32'h0);
    clearIn();
    RtD = 7; WriteRegM = 7; RegWriteM = 1;
    #1;
    chk("fwdBD", 32'(ForwardBD), 32'd1);
    chk("fwdAD_none", 32'(ForwardAD), 32'd0);
    chkCtl("fwd_no_stall", 6'b000000);

    // Load-use
    clearIn();
    setLwstall();
    #1;
    chkCtl("lwstall_ctl", 6'b110010);
    tick();
    tick();
    chk("lwstall_cnt", 32'(StallCount), 32'd2);

    // Branch hazards
    clearIn();
    BranchD = 1; RegWriteE = 1; WriteRegE = 4; RtD = 4;
    #1;
    chkCtl("branch_E_ctl", 6'b110010);
    tick();
    RegWriteE = 0; MemtoRegM = 1; WriteRegM = 4;
    #1;
    chkCtl("branch_Mload_ctl", 6'b110010);
    tick();
    chk("branch_cnt", 32'(StallCount), 32'd4);
    MemtoRegM = 0; RegWriteM = 1;
    #1;
    chkCtl("branch_Malu_nostall", 6'b000000);

    // Memory wait: three stalled cycles, lwstall overlapping
    clearIn();
    MemReqM = 1; MemReadyM = 0;
    #1;
    chkCtl("memwait_c1", 6'b111101);
    tick();
    setLwstall();
    #1;
    chkCtl("memwait_c2_lw", 6'b111101);
    tick();
    #1;
    chkCtl("memwait_c3_lw", 6'b111101);
    tick();
    MemReadyM = 1;
    #1;
    chkCtl("memwait_ready_lw", 6'b110010);
    tick();
    chk("memwait_cnt", 32'(StallCount), 32'd8);
    clearIn();
    #1;
    chkCtl("memwait_idle", 6'b000000);
    tick();
    chk("memwait_cnt_hold", 32'(StallCount), 32'd8);

    // Request withdrawn while waiting
    MemReqM = 1; MemReadyM = 0;
    tick();
    MemReqM = 0;
    #1;
    chkCtl("memdrop_ctl", 6'b000000);
    tick();
    chk("memdrop_cnt", 32'(StallCount), 32'd9);

    // Timeout after MEM_TIMEOUT+1 stalled cycles
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("timeout_err_early", 32'(MemErr), 32'd0);
    chkCtl("timeout_c5_ctl", 6'b111101);
    tick();
    chk("timeout_err", 32'(MemErr), 32'd1);
    chk("timeout_cnt", 32'(StallCount), 32'd14);
    MemReadyM = 1;
    #1;
    chkCtl("err_ready_ctl", 6'b111101);
    tick();
    clearIn();
    #1;
    chkCtl("err_idle_inputs", 6'b111101);
    tick();
    chk("err_cnt_sat", 32'(StallCount), 32'd15);
    chk("err_sticky", 32'(MemErr), 32'd1);

    // Asynchronous reset out of ERR
    #2;
    rst = 1'b1;
    #1;
    chk("arst_err", 32'(MemErr), 32'd0);
    chk("arst_cnt", 32'(StallCount), 32'd0);
    chkCtl("arst_ctl", 6'b000000);
    #1;
    rst = 1'b0;
    tick();
    chkCtl("post_rst_ctl", 6'b000000);

    // Saturation under continuous lwstall
    setLwstall();
    for (int i = 0; i < 14; i++) tick();
    chk("sat_cnt14", 32'(StallCount), 32'd14);
    tick();
    chk("sat_cnt15", 32'(StallCount), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_cnt_hold", 32'(StallCount), 32'd15);
    chk("sat_no_err", 32'(MemErr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
